// File: rtl/control_unit_pkg.sv
// MachineV control unit: shared opcodes, ALU codes, state and class encodings.
package control_unit_pkg;

    localparam logic [2:0] OP_STP = 3'b000;
    localparam logic [2:0] OP_DOD = 3'b001;
    localparam logic [2:0] OP_ODE = 3'b010;
    localparam logic [2:0] OP_POB = 3'b011;
    localparam logic [2:0] OP_LAD = 3'b100;
    localparam logic [2:0] OP_SOB = 3'b101;
    localparam logic [2:0] OP_SOM = 3'b110;
    localparam logic [2:0] OP_SOZ = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_READ = 4'd2,
        S_F_LOAD = 4'd3,
        S_DECODE = 4'd4,
        S_E_ADDR = 4'd5,
        S_E_READ = 4'd6,
        S_E_ALU  = 4'd7,
        S_E_STOR = 4'd8,
        S_E_WRIT = 4'd9,
        S_E_JUMP = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        C_STOP   = 3'd0,
        C_ALU    = 3'd1,
        C_STORE  = 3'd2,
        C_JUMP   = 3'd3,
        C_NOJUMP = 3'd4
    } class_e;

    typedef struct packed {
        logic lout;
        logic lin;
        logic inc;
        logic iout;
        logic iin;
        logic ain;
        logic rd;
        logic wr;
        logic sout;
        logic sin;
        logic accin;
        logic accout;
        logic done;
        logic halted;
    } strobe_t;

    // Strobes owned by each state; aluop and decode-time done are added by the core.
    function automatic strobe_t state_strobes(state_e s);
        strobe_t st;
        st = '0;
        case (s)
            S_F_ADDR: begin st.lout = 1'b1; st.ain = 1'b1; end
            S_F_READ: begin st.rd = 1'b1; st.inc = 1'b1; end
            S_F_LOAD: begin st.sout = 1'b1; st.iin = 1'b1; end
            S_E_ADDR: begin st.iout = 1'b1; st.ain = 1'b1; end
            S_E_READ: st.rd = 1'b1;
            S_E_ALU: begin
                st.sout  = 1'b1;
                st.accin = 1'b1;
                st.done  = 1'b1;
            end
            S_E_STOR: begin st.accout = 1'b1; st.sin = 1'b1; end
            S_E_WRIT: begin st.wr = 1'b1; st.done = 1'b1; end
            S_E_JUMP: begin
                st.iout = 1'b1;
                st.lin  = 1'b1;
                st.done = 1'b1;
            end
            S_HALT:   st.halted = 1'b1;
            default:  st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_unit_opcode_decode.sv
// MachineV opcode classifier: maps opcode and accumulator flags to an
// instruction class and the ALU operation it needs.
module control_unit_opcode_decode
    import control_unit_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic       acc_neg_i,
    input  logic       acc_zero_i,
    output logic [2:0] cls_o,
    output logic [1:0] aluop_o
);

    class_e cls;

    always_comb begin
        cls     = C_STOP;
        aluop_o = ALU_PASS;
        unique case (opcode_i)
            OP_STP: cls = C_STOP;
            OP_DOD: begin cls = C_ALU; aluop_o = ALU_ADD; end
            OP_ODE: begin cls = C_ALU; aluop_o = ALU_SUB; end
            OP_POB: cls = C_ALU;
            OP_LAD: cls = C_STORE;
            OP_SOB: cls = C_JUMP;
            OP_SOM: cls = acc_neg_i  ? C_JUMP : C_NOJUMP;
            OP_SOZ: cls = acc_zero_i ? C_JUMP : C_NOJUMP;
            default: cls = C_STOP;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/control_unit.sv
// MachineV fetch/execute sequencer: one state per cycle, strobes registered
// alongside the state so they are glitch-free and follow the state exactly.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       step,
    input  logic [2:0] opcode,
    input  logic       acc_neg,
    input  logic       acc_zero,
    output logic       Lout,
    output logic       Lin,
    output logic       inc,
    output logic       Iout,
    output logic       Iin,
    output logic       Ain,
    output logic       rd,
    output logic       wr,
    output logic       Sout,
    output logic       Sin,
    output logic       ACCin,
    output logic       ACCout,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       halted
);

    state_e     state_q, state_d;
    class_e     cls_q;
    class_e     cls_now;
    logic [2:0] dec_cls;
    logic [1:0] dec_aluop;
    logic [1:0] alu_q;
    logic [1:0] aluop_q;
    strobe_t    str_q;
    state_e     end_st;
    logic       dec_done;

    control_unit_opcode_decode u_dec (
        .opcode_i   (opcode),
        .acc_neg_i  (acc_neg),
        .acc_zero_i (acc_zero),
        .cls_o      (dec_cls),
        .aluop_o    (dec_aluop)
    );

    assign cls_now = class_e'(dec_cls);
    assign end_st  = step ? S_IDLE : S_F_ADDR;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_F_ADDR;
            S_HALT:   if (start) state_d = S_F_ADDR;
            S_F_ADDR: state_d = S_F_READ;
            S_F_READ: state_d = S_F_LOAD;
            S_F_LOAD: state_d = S_DECODE;
            S_DECODE: begin
                unique case (cls_now)
                    C_STOP:   state_d = S_HALT;
                    C_ALU:    state_d = S_E_ADDR;
                    C_STORE:  state_d = S_E_ADDR;
                    C_JUMP:   state_d = S_E_JUMP;
                    C_NOJUMP: state_d = end_st;
                    default:  state_d = S_IDLE;
                endcase
            end
            S_E_ADDR: state_d = (cls_q == C_ALU) ? S_E_READ : S_E_STOR;
            S_E_READ: state_d = S_E_ALU;
            S_E_ALU:  state_d = end_st;
            S_E_STOR: state_d = S_E_WRIT;
            S_E_WRIT: state_d = end_st;
            S_E_JUMP: state_d = end_st;
            default:  state_d = S_IDLE;
        endcase
    end

    // Class and ALU op are frozen in DECODE so later flag changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cls_q   <= C_STOP;
            alu_q   <= ALU_PASS;
            aluop_q <= ALU_PASS;
            str_q   <= '0;
        end else begin
            state_q <= state_d;
            str_q   <= state_strobes(state_d);
            aluop_q <= (state_d == S_E_ALU) ? alu_q : ALU_PASS;
            if (state_q == S_DECODE) begin
                cls_q <= cls_now;
                alu_q <= dec_aluop;
            end
        end
    end

    assign dec_done = (state_q == S_DECODE) &&
                      ((cls_now == C_STOP) || (cls_now == C_NOJUMP));

    assign Lout       = str_q.lout;
    assign Lin        = str_q.lin;
    assign inc        = str_q.inc;
    assign Iout       = str_q.iout;
    assign Iin        = str_q.iin;
    assign Ain        = str_q.ain;
    assign rd         = str_q.rd;
    assign wr         = str_q.wr;
    assign Sout       = str_q.sout;
    assign Sin        = str_q.sin;
    assign ACCin      = str_q.accin;
    assign ACCout     = str_q.accout;
    assign aluop      = aluop_q;
    assign instr_done = str_q.done | dec_done;
    assign halted     = str_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against an instruction-level
// model built from per-class cycle tables.
module tb_control_unit;

    logic       CLK = 1'b0;
    logic       RST, start, step, acc_neg, acc_zero;
    logic [2:0] opcode;
    logic       Lout, Lin, inc, Iout, Iin, Ain, rd, wr;
    logic       Sout, Sin, ACCin, ACCout, instr_done, halted;
    logic [1:0] aluop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    control_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .step(step),
        .opcode(opcode), .acc_neg(acc_neg), .acc_zero(acc_zero),
        .Lout(Lout), .Lin(Lin), .inc(inc), .Iout(Iout), .Iin(Iin),
        .Ain(Ain), .rd(rd), .wr(wr), .Sout(Sout), .Sin(Sin),
        .ACCin(ACCin), .ACCout(ACCout), .aluop(aluop),
        .instr_done(instr_done), .halted(halted)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // kinds: 0 stop, 1 alu, 2 store, 3 jump, 4 branch not taken
    function automatic int kind_of(logic [2:0] op, logic n, logic z);
        case (op)
            3'd0: return 0;
            3'd1, 3'd2, 3'd3: return 1;
            3'd4: return 2;
            3'd5: return 3;
            3'd6: return n ? 3 : 4;
            default: return z ? 3 : 4;
        endcase
    endfunction

    function automatic int lat_of(int kd);
        if (kd == 1 || kd == 2) return 7;
        if (kd == 3) return 5;
        return 4;
    endfunction

    // bit order: Lout Lin inc Iout Iin Ain rd wr Sout Sin ACCin ACCout aluop[1:0] done halted
    function automatic logic [15:0] expect_vec(int mode, int k, int kd,
                                               logic [2:0] opl);
        logic [15:0] e;
        e = '0;
        if (mode == 2) e[0] = 1'b1;
        if (mode == 1) begin
            if (k == 1) begin e[15] = 1; e[10] = 1; end
            if (k == 2) begin e[9] = 1; e[13] = 1; end
            if (k == 3) begin e[7] = 1; e[11] = 1; end
            if (k == 4 && (kd == 0 || kd == 4)) e[1] = 1;
            if (k == 5 && kd != 3) begin e[12] = 1; e[10] = 1; end
            if (k == 5 && kd == 3) begin
                e[12] = 1; e[14] = 1; e[1] = 1;
            end
            if (k == 6 && kd == 1) e[9] = 1;
            if (k == 6 && kd == 2) begin e[4] = 1; e[6] = 1; end
            if (k == 7 && kd == 1) begin
                e[7] = 1; e[5] = 1; e[1] = 1;
                e[3:2] = (opl == 3'd1) ? 2'b01 :
                         (opl == 3'd2) ? 2'b10 : 2'b00;
            end
            if (k == 7 && kd == 2) begin e[8] = 1; e[1] = 1; end
        end
        return e;
    endfunction

    initial begin
        int         mode;
        int         k;
        int         kd;
        logic [2:0] opl;
        logic [15:0] got;
        logic [15:0] exp;
        RST = 1'b1; start = 1'b0; step = 1'b0;
        opcode = 3'd0; acc_neg = 1'b0; acc_zero = 1'b0;
        repeat (2) @(posedge CLK);
        mode = 0; k = 0; kd = 0; opl = 3'd0;
        for (int c = 0; c < 4000; c++) begin
            cyc = c;
            #1;
            if (c == 0 || c < 12) begin
                RST = 1'b0; start = 1'b0; step = 1'b0;
            end else begin
                RST   = ($urandom_range(0, 59) == 0);
                start = ($urandom_range(0, 2) != 0);
                step  = ($urandom_range(0, 3) == 0);
            end
            opcode   = 3'($urandom_range(0, 7));
            acc_neg  = 1'($urandom_range(0, 1));
            acc_zero = 1'($urandom_range(0, 1));
            if (mode == 1 && k == 4) begin
                kd  = kind_of(opcode, acc_neg, acc_zero);
                opl = opcode;
            end
            #1;
            got = {Lout, Lin, inc, Iout, Iin, Ain, rd, wr, Sout, Sin,
                   ACCin, ACCout, aluop, instr_done, halted};
            exp = expect_vec(mode, k, kd, opl);
            chk("strobes", got, exp);
            chk("abus", {15'd0, Lout & Iout}, 16'd0);
            chk("dbus", {15'd0, Sout & ACCout}, 16'd0);
            @(posedge CLK);
            if (RST) begin
                mode = 0;
                k = 0;
            end else if (mode != 1) begin
                if (start) begin mode = 1; k = 1; end
            end else if (k == lat_of(kd) && k >= 4) begin
                if (kd == 0) mode = 2;
                else if (step) mode = 0;
                else k = 1;
            end else begin
                k++;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
